// File: rtl/gcbp_row_sequencer_if.sv
// Line-generator to BRAM-array bundle for the GCBP row sequencer.
// The master side is the line generator and BRAM array; the slave side is the sequencer.
interface gcbp_row_sequencer_if #(
    parameter int unsigned C_SUBIMAGE_H = 64,
    parameter int unsigned C_NUM_VERT   = 4,
    parameter int unsigned C_NUM_HORI   = 4,
    parameter int unsigned C_DATA_W     = 128
);
    localparam int unsigned C_RB = (C_NUM_VERT > 1) ? $clog2(C_NUM_VERT) : 1;
    localparam int unsigned C_HB = (C_NUM_HORI > 1) ? $clog2(C_NUM_HORI) : 1;
    localparam int unsigned C_LB = $clog2(C_SUBIMAGE_H);
    localparam int unsigned C_AW = 2 + C_LB;
    localparam int unsigned C_NW = C_NUM_VERT * C_NUM_HORI;

    logic                i_new_frame;
    logic                i_line_end;
    logic                i_word_valid;
    logic [C_DATA_W-1:0] i_word;
    logic [C_HB-1:0]     i_hori_idx;
    logic [C_NW-1:0]     o_bram_we;
    logic [C_AW-1:0]     o_bram_waddr;
    logic [C_DATA_W-1:0] o_bram_wdata;
    logic [1:0]          o_next_frame_loc;
    logic [1:0]          o_curr_frame_loc;
    logic [1:0]          o_prev_frame_loc;
    logic [C_RB-1:0]     o_vert_idx;
    logic                o_frame_done;
    logic                o_frame_abort;

    modport master (
        output i_new_frame, i_line_end, i_word_valid, i_word, i_hori_idx,
        input  o_bram_we, o_bram_waddr, o_bram_wdata, o_next_frame_loc,
               o_curr_frame_loc, o_prev_frame_loc, o_vert_idx, o_frame_done, o_frame_abort
    );

    modport slave (
        input  i_new_frame, i_line_end, i_word_valid, i_word, i_hori_idx,
        output o_bram_we, o_bram_waddr, o_bram_wdata, o_next_frame_loc,
               o_curr_frame_loc, o_prev_frame_loc, o_vert_idx, o_frame_done, o_frame_abort
    );
endinterface

// File: rtl/gcbp_row_sequencer.sv
// Tracks the vertical position in a frame, routes sub-image words into the BRAM array
// and rotates the triple-buffered frame slots once a frame completes.
module gcbp_row_sequencer #(
    parameter int unsigned C_LINES_PER_FRAME = 480,
    parameter int unsigned C_SUBIMAGE_H      = 64,
    parameter int unsigned C_NUM_VERT        = 4,
    parameter int unsigned C_NUM_HORI        = 4,
    parameter int unsigned C_EDGE_GAP        = 46,
    parameter int unsigned C_INTER_GAP       = 44,
    parameter int unsigned C_DATA_W          = 128
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    gcbp_row_sequencer_if.slave  bus
);
    localparam int unsigned C_RB   = (C_NUM_VERT > 1) ? $clog2(C_NUM_VERT) : 1;
    localparam int unsigned C_HB   = (C_NUM_HORI > 1) ? $clog2(C_NUM_HORI) : 1;
    localparam int unsigned C_LB   = $clog2(C_SUBIMAGE_H);
    localparam int unsigned C_AW   = 2 + C_LB;
    localparam int unsigned C_NW   = C_NUM_VERT * C_NUM_HORI;
    localparam int unsigned C_IW   = (C_NW > 1) ? $clog2(C_NW) : 1;
    localparam int unsigned C_GMAX = (C_EDGE_GAP > C_INTER_GAP) ? C_EDGE_GAP : C_INTER_GAP;
    localparam int unsigned C_GB   = (C_GMAX > 1) ? $clog2(C_GMAX) : 1;
    localparam bit C_GEOM_OK = (2 * C_EDGE_GAP + (C_NUM_VERT - 1) * C_INTER_GAP
                                + C_NUM_VERT * C_SUBIMAGE_H) == C_LINES_PER_FRAME;

    typedef enum logic [1:0] {S_WAIT, S_GAP, S_ROW, S_TAIL} state_t;

    state_t              state_q;
    logic [C_GB-1:0]     gap_cnt_q;
    logic [C_LB-1:0]     row_line_q;
    logic [C_RB-1:0]     vert_idx_q;
    logic [1:0]          next_q, curr_q, prev_q;
    logic [C_NW-1:0]     we_q;
    logic [C_AW-1:0]     waddr_q;
    logic [C_DATA_W-1:0] wdata_q;
    logic                done_q, abort_q;

    logic [C_GB-1:0] gap_last;
    logic            row_last, vert_last, hori_ok, write_ok;
    logic [C_IW-1:0] we_idx;

    // Indices beyond the configured column count are dropped rather than aliased.
    if (C_NUM_HORI == (1 << C_HB)) begin : g_hori_full
        assign hori_ok = 1'b1;
    end else begin : g_hori_part
        assign hori_ok = (32'(bus.i_hori_idx) < C_NUM_HORI);
    end

    always_comb begin
        gap_last  = (vert_idx_q == '0) ? C_GB'(C_EDGE_GAP - 1) : C_GB'(C_INTER_GAP - 1);
        row_last  = (row_line_q == C_LB'(C_SUBIMAGE_H - 1));
        vert_last = (vert_idx_q == C_RB'(C_NUM_VERT - 1));
        we_idx    = C_IW'(vert_idx_q) * C_IW'(C_NUM_HORI) + C_IW'(bus.i_hori_idx);
        write_ok  = bus.i_word_valid && (state_q == S_ROW) && !bus.i_new_frame && hori_ok;
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state_q    <= S_WAIT;
            gap_cnt_q  <= '0;
            row_line_q <= '0;
            vert_idx_q <= '0;
            next_q     <= 2'd0;
            curr_q     <= 2'd1;
            prev_q     <= 2'd2;
            we_q       <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            we_q    <= '0;
            // Write uses pre-update position, so a word on the ending line stays in that line.
            if (write_ok) begin
                we_q    <= C_NW'(1) << we_idx;
                waddr_q <= {next_q, row_line_q};
                wdata_q <= bus.i_word;
            end
            if (bus.i_new_frame) begin
                state_q    <= S_GAP;
                gap_cnt_q  <= '0;
                vert_idx_q <= '0;
                if (state_q == S_TAIL) begin
                    next_q <= prev_q;
                    curr_q <= next_q;
                    prev_q <= curr_q;
                end else if (state_q != S_WAIT) begin
                    abort_q <= 1'b1;
                end
            end else if (bus.i_line_end) begin
                unique case (state_q)
                    S_GAP: begin
                        if (gap_cnt_q == gap_last) begin
                            state_q    <= S_ROW;
                            row_line_q <= '0;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + C_GB'(1);
                        end
                    end
                    S_ROW: begin
                        if (!row_last) begin
                            row_line_q <= row_line_q + C_LB'(1);
                        end else if (vert_last) begin
                            state_q <= S_TAIL;
                            done_q  <= 1'b1;
                        end else begin
                            vert_idx_q <= vert_idx_q + C_RB'(1);
                            gap_cnt_q  <= '0;
                            state_q    <= S_GAP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Frame geometry must add up to the active line count.
    always_ff @(posedge i_clk) begin
        a_geom: assert (C_GEOM_OK) else $error("gcbp_row_sequencer: frame geometry does not sum to C_LINES_PER_FRAME");
    end

    assign bus.o_bram_we        = we_q;
    assign bus.o_bram_waddr     = waddr_q;
    assign bus.o_bram_wdata     = wdata_q;
    assign bus.o_next_frame_loc = next_q;
    assign bus.o_curr_frame_loc = curr_q;
    assign bus.o_prev_frame_loc = prev_q;
    assign bus.o_vert_idx       = vert_idx_q;
    assign bus.o_frame_done     = done_q;
    assign bus.o_frame_abort    = abort_q;
endmodule

// File: tb/tb_gcbp_row_sequencer.sv
// Bench for gcbp_row_sequencer: three geometries against a line-counting frame model.
module tb_gcbp_row_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcbp_row_sequencer_if bus0 ();
    gcbp_row_sequencer_if #(.C_SUBIMAGE_H(4), .C_NUM_VERT(2), .C_NUM_HORI(2), .C_DATA_W(16)) bus1 ();
    gcbp_row_sequencer_if #(.C_SUBIMAGE_H(4), .C_NUM_VERT(2), .C_NUM_HORI(3), .C_DATA_W(16)) bus2 ();

    gcbp_row_sequencer u0 (.i_clk(clk), .i_resetn(rst_n), .bus(bus0));
    gcbp_row_sequencer #(.C_LINES_PER_FRAME(12), .C_SUBIMAGE_H(4), .C_NUM_VERT(2), .C_NUM_HORI(2),
                         .C_EDGE_GAP(1), .C_INTER_GAP(2), .C_DATA_W(16))
        u1 (.i_clk(clk), .i_resetn(rst_n), .bus(bus1));
    gcbp_row_sequencer #(.C_LINES_PER_FRAME(12), .C_SUBIMAGE_H(4), .C_NUM_VERT(2), .C_NUM_HORI(3),
                         .C_EDGE_GAP(1), .C_INTER_GAP(2), .C_DATA_W(16))
        u2 (.i_clk(clk), .i_resetn(rst_n), .bus(bus2));

    int c_h[3]     = '{64, 4, 4};
    int c_v[3]     = '{4, 2, 2};
    int c_hori[3]  = '{4, 2, 3};
    int c_edge[3]  = '{46, 1, 1};
    int c_inter[3] = '{44, 2, 2};

    int tests = 0;
    int fails = 0;
    int n_writes = 0;

    // Model: a frame is just a count of line_end pulses since i_new_frame.
    bit           m_started[3];
    int           m_line[3];
    int           m_next[3], m_curr[3], m_prev[3];
    int           m_waddr[3];
    logic [127:0] m_wdata[3];

    // Most recent DUT sample, for directed checks in the scenario tasks.
    logic [31:0]  s_we;
    int           s_addr, s_vert, s_next, s_curr, s_prev;
    logic [127:0] s_data;
    bit           s_done, s_abort;

    function automatic int tot_lines(input int d);
        return c_edge[d] + c_v[d] * c_h[d] + (c_v[d] - 1) * c_inter[d];
    endfunction

    function automatic int row_of(input int d, input int l, output int rl);
        for (int r = 0; r < c_v[d]; r++) begin
            int s;
            s = c_edge[d] + r * (c_h[d] + c_inter[d]);
            if (l >= s && l < s + c_h[d]) begin
                rl = l - s;
                return r;
            end
        end
        rl = 0;
        return -1;
    endfunction

    function automatic int rows_done(input int d, input int l);
        int n;
        n = 0;
        for (int r = 0; r < c_v[d]; r++)
            if (c_edge[d] + r * (c_h[d] + c_inter[d]) + c_h[d] <= l) n++;
        return n;
    endfunction

    function automatic logic [127:0] rword();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int rand_hori(input int d);
        return (d == 1) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_started[d] = 1'b0; m_line[d] = 0;
            m_next[d] = 0; m_curr[d] = 1; m_prev[d] = 2;
            m_waddr[d] = 0; m_wdata[d] = '0;
        end
    endtask

    task automatic drive_idle();
        bus0.i_new_frame = 1'b0; bus0.i_line_end = 1'b0; bus0.i_word_valid = 1'b0;
        bus1.i_new_frame = 1'b0; bus1.i_line_end = 1'b0; bus1.i_word_valid = 1'b0;
        bus2.i_new_frame = 1'b0; bus2.i_line_end = 1'b0; bus2.i_word_valid = 1'b0;
    endtask

    task automatic sample(input int d);
        case (d)
            0: begin
                s_we = 32'(bus0.o_bram_we); s_addr = int'(bus0.o_bram_waddr); s_data = 128'(bus0.o_bram_wdata);
                s_next = int'(bus0.o_next_frame_loc); s_curr = int'(bus0.o_curr_frame_loc);
                s_prev = int'(bus0.o_prev_frame_loc); s_vert = int'(bus0.o_vert_idx);
                s_done = bus0.o_frame_done; s_abort = bus0.o_frame_abort;
            end
            1: begin
                s_we = 32'(bus1.o_bram_we); s_addr = int'(bus1.o_bram_waddr); s_data = 128'(bus1.o_bram_wdata);
                s_next = int'(bus1.o_next_frame_loc); s_curr = int'(bus1.o_curr_frame_loc);
                s_prev = int'(bus1.o_prev_frame_loc); s_vert = int'(bus1.o_vert_idx);
                s_done = bus1.o_frame_done; s_abort = bus1.o_frame_abort;
            end
            default: begin
                s_we = 32'(bus2.o_bram_we); s_addr = int'(bus2.o_bram_waddr); s_data = 128'(bus2.o_bram_wdata);
                s_next = int'(bus2.o_next_frame_loc); s_curr = int'(bus2.o_curr_frame_loc);
                s_prev = int'(bus2.o_prev_frame_loc); s_vert = int'(bus2.o_vert_idx);
                s_done = bus2.o_frame_done; s_abort = bus2.o_frame_abort;
            end
        endcase
    endtask

    // One clock on instance d: drive, advance the model, compare every output.
    task automatic step(input int d, input bit nf, input bit le, input bit wv,
                        input logic [127:0] w, input int hori);
        logic [31:0] e_we;
        bit e_done, e_abort;
        int e_vert, r, rl, t;
        drive_idle();
        case (d)
            0: begin bus0.i_new_frame = nf; bus0.i_line_end = le; bus0.i_word_valid = wv;
                     bus0.i_word = w; bus0.i_hori_idx = 2'(hori); end
            1: begin bus1.i_new_frame = nf; bus1.i_line_end = le; bus1.i_word_valid = wv;
                     bus1.i_word = w[15:0]; bus1.i_hori_idx = 1'(hori); end
            default: begin bus2.i_new_frame = nf; bus2.i_line_end = le; bus2.i_word_valid = wv;
                     bus2.i_word = w[15:0]; bus2.i_hori_idx = 2'(hori); end
        endcase
        if (d != 0) w = {112'd0, w[15:0]};
        e_we = '0; e_done = 1'b0; e_abort = 1'b0;
        if (nf) begin
            if (m_started[d] && m_line[d] >= tot_lines(d)) begin
                t = m_next[d]; m_next[d] = m_prev[d]; m_prev[d] = m_curr[d]; m_curr[d] = t;
            end else if (m_started[d]) begin
                e_abort = 1'b1;
            end
            m_started[d] = 1'b1;
            m_line[d] = 0;
        end else if (m_started[d]) begin
            r = row_of(d, m_line[d], rl);
            if (wv && r >= 0 && hori < c_hori[d]) begin
                e_we = 32'(1) << (r * c_hori[d] + hori);
                m_waddr[d] = m_next[d] * c_h[d] + rl;
                m_wdata[d] = w;
            end
            if (le && m_line[d] < tot_lines(d)) begin
                m_line[d]++;
                if (m_line[d] == tot_lines(d)) e_done = 1'b1;
            end
        end
        e_vert = 0;
        if (m_started[d]) e_vert = (rows_done(d, m_line[d]) > c_v[d] - 1) ? c_v[d] - 1 : rows_done(d, m_line[d]);
        @(posedge clk);
        #1;
        sample(d);
        if (s_we != 0) n_writes++;
        tests++; if (s_we !== e_we) begin fails++; $display("FAIL we d%0d t=%0t got %h want %h", d, $time, s_we, e_we); end
        tests++; if (s_addr != m_waddr[d]) begin fails++; $display("FAIL waddr d%0d t=%0t got %0d want %0d", d, $time, s_addr, m_waddr[d]); end
        tests++; if (s_data !== m_wdata[d]) begin fails++; $display("FAIL wdata d%0d t=%0t got %h want %h", d, $time, s_data, m_wdata[d]); end
        tests++; if (s_done != e_done) begin fails++; $display("FAIL done d%0d t=%0t got %0d want %0d", d, $time, s_done, e_done); end
        tests++; if (s_abort != e_abort) begin fails++; $display("FAIL abort d%0d t=%0t got %0d want %0d", d, $time, s_abort, e_abort); end
        tests++; if (s_vert != e_vert) begin fails++; $display("FAIL vert d%0d t=%0t got %0d want %0d", d, $time, s_vert, e_vert); end
        tests++;
        if (s_next != m_next[d] || s_curr != m_curr[d] || s_prev != m_prev[d]) begin
            fails++;
            $display("FAIL slots d%0d t=%0t got %0d/%0d/%0d want %0d/%0d/%0d", d, $time,
                     s_next, s_curr, s_prev, m_next[d], m_curr[d], m_prev[d]);
        end
    endtask

    // fh >= 0: one word per line at column fh; fh < 0: random words, some on the line_end cycle.
    task automatic run_lines(input int d, input int n, input int fh);
        for (int i = 0; i < n; i++) begin
            step(d, 1'b0, 1'b0, (fh >= 0) ? 1'b1 : 1'($urandom_range(0, 1)), rword(),
                 (fh >= 0) ? fh : rand_hori(d));
            step(d, 1'b0, 1'b1, (fh >= 0) ? 1'b0 : 1'($urandom_range(0, 1)), rword(),
                 (fh >= 0) ? fh : rand_hori(d));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int d = 0; d < 3; d++) begin
            sample(d);
            tests++; if (s_we !== 32'd0 || s_addr != 0 || s_data !== 128'd0) begin
                fails++; $display("FAIL reset_bram d%0d got we=%h addr=%0d data=%h want 0", d, s_we, s_addr, s_data); end
            tests++; if (s_next != 0 || s_curr != 1 || s_prev != 2) begin
                fails++; $display("FAIL reset_slots d%0d got %0d/%0d/%0d want 0/1/2", d, s_next, s_curr, s_prev); end
            tests++; if (s_vert != 0 || s_done || s_abort) begin
                fails++; $display("FAIL reset_flags d%0d got vert=%0d done=%0d abort=%0d want 0", d, s_vert, s_done, s_abort); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_frame();
        n_writes = 0;
        step(0, 1'b1, 1'b0, 1'b0, rword(), 0);
        run_lines(0, 480, 2);
        tests++; if (n_writes != 256) begin fails++; $display("FAIL frame_writes got %0d want 256", n_writes); end
        tests++; if (s_next != 0 || s_curr != 1 || s_prev != 2) begin
            fails++; $display("FAIL frame_slots got %0d/%0d/%0d want 0/1/2", s_next, s_curr, s_prev); end
    endtask

    task automatic test_rotation();
        step(0, 1'b1, 1'b0, 1'b0, rword(), 0);
        tests++; if (s_next != 2 || s_curr != 0 || s_prev != 1) begin
            fails++; $display("FAIL rot1 got %0d/%0d/%0d want 2/0/1", s_next, s_curr, s_prev); end
        run_lines(0, 46, -1);
        step(0, 1'b0, 1'b0, 1'b1, rword(), 1);
        tests++; if (s_we !== 32'h2 || s_addr != 128) begin
            fails++; $display("FAIL rot_first_write got we=%h addr=%0d want we=2 addr=128", s_we, s_addr); end
        run_lines(0, 480 - 46, -1);
        step(0, 1'b1, 1'b0, 1'b0, rword(), 0);
        tests++; if (s_next != 1 || s_curr != 2 || s_prev != 0) begin
            fails++; $display("FAIL rot2 got %0d/%0d/%0d want 1/2/0", s_next, s_curr, s_prev); end
    endtask

    task automatic test_abort();
        run_lines(0, 201, -1);
        step(0, 1'b1, 1'b0, 1'b0, rword(), 0);
        tests++; if (!s_abort) begin fails++; $display("FAIL abort_pulse got 0 want 1"); end
        tests++; if (s_next != 1 || s_curr != 2 || s_prev != 0) begin
            fails++; $display("FAIL abort_slots got %0d/%0d/%0d want 1/2/0", s_next, s_curr, s_prev); end
        run_lines(0, 46, -1);
        step(0, 1'b0, 1'b0, 1'b1, rword(), 2);
        tests++; if (s_we !== 32'h4 || s_addr != 64) begin
            fails++; $display("FAIL abort_rewrite got we=%h addr=%0d want we=4 addr=64", s_we, s_addr); end
    endtask

    task automatic test_same_cycle();
        run_lines(0, 63, -1);
        step(0, 1'b0, 1'b1, 1'b1, rword(), 2);
        tests++; if (s_we !== 32'h4 || s_addr != 127) begin
            fails++; $display("FAIL last_line_word got we=%h addr=%0d want we=4 addr=127", s_we, s_addr); end
        step(0, 1'b0, 1'b0, 1'b1, rword(), 2);
        tests++; if (s_we !== 32'h0) begin fails++; $display("FAIL gap_word got we=%h want 0", s_we); end
    endtask

    task automatic test_new_frame_priority();
        run_lines(0, 44, -1);
        step(0, 1'b1, 1'b1, 1'b1, rword(), 1);
        tests++; if (s_we !== 32'h0 || !s_abort) begin
            fails++; $display("FAIL nf_priority got we=%h abort=%0d want we=0 abort=1", s_we, s_abort); end
    endtask

    task automatic test_bad_hori();
        step(2, 1'b1, 1'b0, 1'b0, rword(), 0);
        step(2, 1'b0, 1'b1, 1'b0, rword(), 0);
        step(2, 1'b0, 1'b0, 1'b1, rword(), 3);
        tests++; if (s_we !== 32'h0) begin fails++; $display("FAIL bad_hori got we=%h want 0", s_we); end
        step(2, 1'b0, 1'b0, 1'b1, rword(), 2);
        tests++; if (s_we !== 32'h4) begin fails++; $display("FAIL good_hori got we=%h want 4", s_we); end
        run_lines(2, 11, -1);
        for (int f = 0; f < 3; f++) begin
            step(2, 1'b1, 1'b0, 1'b0, rword(), 0);
            run_lines(2, 12 + int'($urandom_range(0, 2)), -1);
        end
    endtask

    task automatic test_back_to_back_small();
        step(1, 1'b1, 1'b0, 1'b0, rword(), 0);
        run_lines(1, 2, 1);
        rst_n = 1'b0;
        drive_idle();
        bus1.i_word_valid = 1'b1; bus1.i_hori_idx = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        sample(1);
        tests++; if (s_we !== 32'h0 || s_next != 0 || s_curr != 1 || s_prev != 2) begin
            fails++; $display("FAIL mid_reset got we=%h slots=%0d/%0d/%0d want 0 0/1/2", s_we, s_next, s_curr, s_prev); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 1'b0, 1'(i % 2), 1'b1, rword(), 0);
        n_writes = 0;
        step(1, 1'b1, 1'b0, 1'b0, rword(), 0);
        run_lines(1, 12, 0);
        tests++; if (n_writes != 8) begin fails++; $display("FAIL small_writes got %0d want 8", n_writes); end
        run_lines(1, 3, -1);
        step(1, 1'b1, 1'b0, 1'b0, rword(), 0);
        tests++; if (s_next != 2 || s_curr != 0 || s_prev != 1 || s_abort) begin
            fails++; $display("FAIL small_rot got %0d/%0d/%0d abort=%0d want 2/0/1 0", s_next, s_curr, s_prev, s_abort); end
        for (int f = 0; f < 4; f++) begin
            run_lines(1, 8 + int'($urandom_range(0, 6)), -1);
            step(1, 1'b1, 1'b0, 1'b0, rword(), 0);
        end
    endtask

    initial begin
        drive_idle();
        bus0.i_word = '0; bus0.i_hori_idx = '0;
        bus1.i_word = '0; bus1.i_hori_idx = '0;
        bus2.i_word = '0; bus2.i_hori_idx = '0;
        test_reset();
        test_full_frame();
        test_rotation();
        test_abort();
        test_same_cycle();
        test_new_frame_priority();
        test_bad_hori();
        test_back_to_back_small();
        drive_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
